sc_nary_mul: RTL

Stochastic-computing serial multiplier generalised to NUM_INPUTS operands, with a start/busy/done handshake and an enable stall. On start it latches all binary operands. It converts each operand to a unipolar bitstream of 2^DATA_WIDTH bits and ANDs the streams, or XNORs them in bipolar builds. It counts the ones and returns the count as a binary product. It sits inside the arch-sweep core wrapper as the drop-in next generation of the two-input serial multiplier.

---
 rtl/sc_pkg.sv | 53 +++++
 rtl/sc_sng.sv | 48 ++++
 rtl/sc_nary_mul.sv | 116 +++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// ============================================================================
// Module : sc_pkg
// Brief  : Shared types, LFSR tap table, channel seeds and de Bruijn step
//          for the stochastic-computing n-ary multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int C_MIN_WIDTH    = 4;
    localparam int C_MAX_WIDTH    = 16;
    localparam int C_MAX_CHANNELS = 8;

    // Maximal-length Fibonacci taps (shift-left, MSB always tapped).
    localparam logic [15:0] C_LFSR_TAPS [C_MIN_WIDTH:C_MAX_WIDTH] = '{
        16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
        16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
    };

    // Channel 0 is the ramp and must start at zero; the rest stay distinct
    // and non-zero after truncation to any legal width.
    localparam logic [15:0] C_SEED_BASE [0:C_MAX_CHANNELS-1] = '{
        16'h0000, 16'h0001, 16'hA5C3, 16'h3C96,
        16'h5A69, 16'h9E37, 16'h6B1D, 16'hC2F4
    };

    function automatic logic [15:0] width_mask(input int width);
        return 16'((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [15:0] sng_seed(input int width, input int channel);
        return C_SEED_BASE[channel] & width_mask(width);
    endfunction

    // The all-zero state is spliced in after 100..0, so every value appears once.
    function automatic logic [15:0] debruijn_next(input logic [15:0] s, input int width);
        logic [15:0] mask;
        logic        fb;
        mask = width_mask(width);
        fb   = (^(s & C_LFSR_TAPS[width])) ^ ((s & (mask >> 1)) == 16'd0);
        return ((s << 1) | {15'd0, fb}) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_sng.sv
// ============================================================================
// Module : sc_sng
// Brief  : Stochastic number generator: ramp (channel 0) or de Bruijn LFSR
//          reference compared against the operand, bit = (x > r).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sc_sng
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CHANNEL    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] x,
    output logic                  bit_out
);

    localparam logic [DATA_WIDTH-1:0] C_SEED = DATA_WIDTH'(sng_seed(DATA_WIDTH, CHANNEL));

    logic [DATA_WIDTH-1:0] r_ref;
    logic [DATA_WIDTH-1:0] w_next;

    generate
        if (CHANNEL == 0) begin : g_ramp
            assign w_next = r_ref + DATA_WIDTH'(1);
        end else begin : g_lfsr
            assign w_next = DATA_WIDTH'(debruijn_next(16'(r_ref), DATA_WIDTH));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_ref <= C_SEED;
        end else if (adv) begin
            r_ref <= w_next;
        end
    end

    assign bit_out = (x > r_ref);

endmodule

`default_nettype wire

// File: rtl/sc_nary_mul.sv
// ============================================================================
// Module : sc_nary_mul
// Brief  : N-operand stochastic serial multiplier with start/busy/done.
//          Define SC_BIPOLAR_EN for XNOR (bipolar) combining; default is AND.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sc_nary_mul
    import sc_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2,
    parameter int W_OUT      = DATA_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
    output logic [W_OUT-1:0]      bin_data_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_WIDTH-1:0] C_LAST = '1;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_x [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [W_OUT-1:0]      r_ones;
    logic [W_OUT-1:0]      r_dout;
    logic                  r_busy;
    logic                  r_done;

    logic [NUM_INPUTS-1:0] w_bits;
    logic                  w_load;
    logic                  w_adv;
    logic                  w_comb;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_adv  = (r_state == ST_RUN) && en;

    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_sng
            sc_sng #(
                .DATA_WIDTH (DATA_WIDTH),
                .CHANNEL    (i)
            ) u_sng (
                .clk     (clk),
                .rst     (rst),
                .load    (w_load),
                .adv     (w_adv),
                .x       (r_x[i]),
                .bit_out (w_bits[i])
            );
        end
    endgenerate

`ifdef SC_BIPOLAR_EN
    // Product is +1 when an even number of streams carry -1 (bit 0).
    assign w_comb = ~(^(~w_bits));
`else
    assign w_comb = &w_bits;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ones  <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            // busy trails the state by one cycle so it covers the done cycle
            r_busy <= (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x     <= bin_data_in;
                        r_cnt   <= '0;
                        r_ones  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        r_cnt  <= r_cnt + DATA_WIDTH'(1);
                        r_ones <= r_ones + W_OUT'(w_comb);
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_dout  <= r_ones;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bin_data_out = r_dout;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

`default_nettype wire
